// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared FSM state and address-direction types for the SRAM March C- BIST
package sram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_UP,
        RW_UP_R,
        RW_UP_W,
        RW_DN_R,
        RW_DN_W,
        R_DN,
        DRAIN,
        DONE
    } bist_state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } bist_dir_e;

    function automatic logic state_busy(bist_state_e s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/sram_bist_if.sv
// sram_bist_if: single-port SRAM macro port (active-low CEN/WEN/BEN, registered Q)
interface sram_bist_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  CEN;
    logic [ADDR_WIDTH-1:0] A;
    logic                  WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [BE_WIDTH-1:0]   BEN;
    logic [DATA_WIDTH-1:0] Q;

    modport master (output CEN, A, WEN, D, BEN, input Q);
    modport slave  (input CEN, A, WEN, D, BEN, output Q);
endinterface

// File: rtl/sram_bist_addr_gen.sv
// sram_bist_addr_gen: up/down word address counter with direction-dependent reload and last-address flag
module sram_bist_addr_gen
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  load,
    input  bist_dir_e             load_dir,
    input  logic                  en,
    input  bist_dir_e             dir,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    // reload to the first address of the next element, otherwise step in the current direction
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            addr <= '0;
        else if (load)
            addr <= (load_dir == DIR_DN) ? '1 : '0;
        else if (en)
            addr <= (dir == DIR_DN) ? addr - 1'b1 : addr + 1'b1;
    end

    assign last = (dir == DIR_DN) ? (addr == '0) : (&addr);

endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- self-test initiator with first-failure capture for a single-port SRAM
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    sram_bist_if.master           mem
);

    bist_state_e           state, state_n;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  cnt_load, cnt_en, last;
    bist_dir_e             cnt_load_dir, cnt_dir;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd, wr;
    logic [DATA_WIDTH-1:0] expected;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic                  accept, mismatch;

    assign busy_o   = state_busy(state);
    assign done_o   = (state == DONE);
    assign accept   = start_i && !busy_o;
    assign mismatch = rd_valid && (mem.Q != rd_exp);

    sram_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .load     (cnt_load),
        .load_dir (cnt_load_dir),
        .en       (cnt_en),
        .dir      (cnt_dir),
        .addr     (addr),
        .last     (last)
    );

    // state register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)
            state <= IDLE;
        else
            state <= state_n;
    end

    // element sequencing: each element ends on its last address and reloads the counter for the next
    always_comb begin
        state_n      = state;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_dir = DIR_UP;
        case (state)
            IDLE, DONE: begin
                state_n  = start_i ? W_UP : state;
                cnt_load = start_i;
            end
            W_UP: begin
                state_n  = last ? RW_UP_R : W_UP;
                cnt_load = last;
                cnt_en   = !last;
            end
            RW_UP_R: state_n = RW_UP_W;
            RW_UP_W: begin
                state_n      = last ? RW_DN_R : RW_UP_R;
                cnt_load     = last;
                cnt_en       = !last;
                cnt_load_dir = DIR_DN;
            end
            RW_DN_R: state_n = RW_DN_W;
            RW_DN_W: begin
                state_n      = last ? R_DN : RW_DN_R;
                cnt_load     = last;
                cnt_en       = !last;
                cnt_load_dir = DIR_DN;
            end
            R_DN: begin
                state_n = last ? DRAIN : R_DN;
                cnt_en  = !last;
            end
            DRAIN:   state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (fail_o && busy_o)
            state_n = DONE;
    end

    // macro port and expected read data decoded from the current state and address
    always_comb begin
        cnt_dir  = (state == RW_DN_R || state == RW_DN_W || state == R_DN) ? DIR_DN : DIR_UP;
        rd       = (state == RW_UP_R || state == RW_DN_R || state == R_DN);
        wr       = (state == W_UP || state == RW_UP_W || state == RW_DN_W);
        expected = (state == RW_DN_R) ? ~pattern : pattern;
        mem.CEN  = !(rd || wr);
        mem.WEN  = !wr;
        mem.A    = addr;
        mem.D    = !wr ? '0 : (state == RW_UP_W) ? ~pattern : pattern;
        mem.BEN  = {BE_WIDTH{1'b0}};
    end

    // read tracking: Q for a read issued this cycle arrives next cycle
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            rd_exp   <= '0;
        end else begin
            rd_valid <= rd;
            rd_addr  <= addr;
            rd_exp   <= expected;
        end
    end

    // background capture on start and sticky first-mismatch record
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pattern     <= '0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
        end else if (accept) begin
            pattern     <= pattern_i;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= '0;
        end else if (mismatch && !fail_o) begin
            fail_o      <= 1'b1;
            fail_addr_o <= rd_addr;
            fail_data_o <= mem.Q;
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: directed March C- runs against a behavioural SRAM with stuck-at fault injection
module tb_sram_march_bist;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int N  = 4;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] pattern_i = '0;
    logic          busy_o, done_o, fail_o;
    logic [AW-1:0] fail_addr_o;
    logic [DW-1:0] fail_data_o;

    sram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    sram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .start_i     (start_i),
        .pattern_i   (pattern_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o),
        .mem         (mem_if)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] ram [N];
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];

    // behavioural macro: byte-masked write, registered read with stuck-at bits forced on the output
    always @(posedge CLK) begin
        if (!mem_if.CEN) begin
            if (!mem_if.WEN) begin
                for (int b = 0; b < DW / 8; b++)
                    if (!mem_if.BEN[b]) ram[mem_if.A][8*b +: 8] <= mem_if.D[8*b +: 8];
            end else
                mem_if.Q <= (ram[mem_if.A] | sa1[mem_if.A]) & ~sa0[mem_if.A];
        end
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic          wen;
        logic [DW-1:0] d;
    } acc_t;

    acc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input logic wen, input logic [DW-1:0] d);
        exp_q.push_back(acc_t'{a: AW'(a), wen: wen, d: d});
    endtask

    task automatic push_march(input logic [DW-1:0] p);
        exp_q.delete();
        for (int a = 0; a < N; a++) push(a, 1'b0, p);
        for (int a = 0; a < N; a++) begin
            push(a, 1'b1, '0);
            push(a, 1'b0, ~p);
        end
        for (int a = N - 1; a >= 0; a--) begin
            push(a, 1'b1, '0);
            push(a, 1'b0, p);
        end
        for (int a = N - 1; a >= 0; a--) push(a, 1'b1, '0);
    endtask

    task automatic go(input logic [DW-1:0] p);
        @(negedge CLK);
        pattern_i = p;
        start_i   = 1'b1;
        @(posedge CLK);
        #1;
        start_i = 1'b0;
        chk("busy_after_start", 64'(busy_o), 64'(1));
        chk("done_cleared", 64'(done_o), 64'(0));
    endtask

    task automatic wait_done(input bit mon, input int pulse, input int exp_n);
        int   n;
        acc_t e;
        n = 0;
        do begin
            @(negedge CLK);
            if (pulse != 0 && n + 1 == pulse) start_i = 1'b1;
            if (mon && !mem_if.CEN) begin
                chk("bus_access_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("bus_A", 64'(mem_if.A), 64'(e.a));
                    chk("bus_WEN", 64'(mem_if.WEN), 64'(e.wen));
                    chk("bus_BEN", 64'(mem_if.BEN), 64'(0));
                    if (!e.wen) chk("bus_D", 64'(mem_if.D), 64'(e.d));
                end
            end
            @(posedge CLK);
            n++;
            #1;
            if (n == pulse) start_i = 1'b0;
        end while (!done_o && n < 200);
        chk("done_latency", 64'(n), 64'(exp_n));
        chk("busy_at_done", 64'(busy_o), 64'(0));
        if (mon) chk("bus_accesses_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_ram(input logic [DW-1:0] p);
        for (int i = 0; i < N; i++) chk("ram_word", 64'(ram[i]), 64'(p));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_fail", 64'(fail_o), 64'(0));
        chk("rst_fail_addr", 64'(fail_addr_o), 64'(0));
        chk("rst_fail_data", 64'(fail_data_o), 64'(0));
        chk("rst_CEN", 64'(mem_if.CEN), 64'(1));
        chk("rst_WEN", 64'(mem_if.WEN), 64'(1));
        chk("rst_A", 64'(mem_if.A), 64'(0));
        chk("rst_D", 64'(mem_if.D), 64'(0));
        chk("rst_BEN", 64'(mem_if.BEN), 64'(0));
        @(negedge CLK);
        RSTN = 1'b1;

        push_march(32'hA5A5_5A5A);
        go(32'hA5A5_5A5A);
        wait_done(1'b1, 0, 6 * N + 1);
        chk("clean_fail", 64'(fail_o), 64'(0));
        chk("clean_CEN_idle", 64'(mem_if.CEN), 64'(1));
        check_ram(32'hA5A5_5A5A);

        sa0[2] = 32'h0000_0001;
        go(32'h0000_0001);
        wait_done(1'b0, 0, 11);
        chk("sa0_fail", 64'(fail_o), 64'(1));
        chk("sa0_addr", 64'(fail_addr_o), 64'(2));
        chk("sa0_data", 64'(fail_data_o), 64'(32'h0000_0000));

        sa0[2] = '0;
        sa1[1] = 32'h8000_0000;
        go(32'h0000_0000);
        wait_done(1'b0, 0, 9);
        chk("sa1_fail", 64'(fail_o), 64'(1));
        chk("sa1_addr", 64'(fail_addr_o), 64'(1));
        chk("sa1_data", 64'(fail_data_o), 64'(32'h8000_0000));
        repeat (5) @(posedge CLK);
        #1;
        chk("sa1_addr_held", 64'(fail_addr_o), 64'(1));
        chk("sa1_data_held", 64'(fail_data_o), 64'(32'h8000_0000));
        chk("sa1_done_held", 64'(done_o), 64'(1));

        sa1[1] = '0;
        sa0[2] = 32'h0000_0001;
        go(32'h0000_0001);
        wait_done(1'b0, 5, 11);
        chk("midstart_fail", 64'(fail_o), 64'(1));
        start_i = 1'b1;
        @(posedge CLK);
        #1;
        chk("restart_done_clr", 64'(done_o), 64'(0));
        chk("restart_fail_clr", 64'(fail_o), 64'(0));
        chk("restart_busy", 64'(busy_o), 64'(1));
        start_i = 1'b0;
        wait_done(1'b0, 0, 11);
        chk("restart_fail", 64'(fail_o), 64'(1));
        chk("restart_addr", 64'(fail_addr_o), 64'(2));
        sa0[2] = '0;

        go(32'h1234_5678);
        repeat (10) @(posedge CLK);
        #2;
        chk("prereset_busy", 64'(busy_o), 64'(1));
        RSTN = 1'b0;
        #1;
        chk("arst_CEN", 64'(mem_if.CEN), 64'(1));
        chk("arst_busy", 64'(busy_o), 64'(0));
        chk("arst_done", 64'(done_o), 64'(0));
        chk("arst_WEN", 64'(mem_if.WEN), 64'(1));
        chk("arst_A", 64'(mem_if.A), 64'(0));
        @(negedge CLK);
        RSTN = 1'b1;
        push_march(32'h3C3C_C3C3);
        go(32'h3C3C_C3C3);
        wait_done(1'b1, 0, 6 * N + 1);
        chk("post_rst_fail", 64'(fail_o), 64'(0));
        check_ram(32'h3C3C_C3C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test initiator for the single-port `generic_memory_data` SRAM macro (active-low CEN/WEN/BEN, 1-cycle registered Q). On a start pulse it runs a March C- sequence over every word, checks read-back data against the expected pattern, and reports pass/fail with the first failing address and data. It sits between the memory macro and the cluster control registers, and drives the macro port only while busy.

## Interface
- ADDR_WIDTH, 12, memory address width; N = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, memory word width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- CLK  in  1  clock
- RSTN  in  1  asynchronous, active-low reset
- start_i  in  1  start request, sampled at posedge; ignored while busy_o=1
- pattern_i  in  DATA_WIDTH  background pattern P, captured on accepted start
- busy_o  out  1  test in progress
- done_o  out  1  test finished; held until next accepted start
- fail_o  out  1  mismatch detected; valid when done_o=1
- fail_addr_o  out  ADDR_WIDTH  address of first mismatch
- fail_data_o  out  DATA_WIDTH  Q value read at first mismatch
- mem_CEN  out  1  chip enable, active low
- mem_A  out  ADDR_WIDTH  address
- mem_WEN  out  1  0 = write, 1 = read
- mem_D  out  DATA_WIDTH  write data
- mem_BEN  out  BE_WIDTH  byte enables, active low; constant all-zero
- mem_Q  in  DATA_WIDTH  read data from macro

## Operation
- Reset values: busy_o=0, done_o=0, fail_o=0, fail_addr_o=0, fail_data_o=0, mem_CEN=1, mem_WEN=1, mem_A=0, mem_D=0, mem_BEN=0.
- FSM states: IDLE, W_UP, RW_UP_R, RW_UP_W, RW_DN_R, RW_DN_W, R_DN, DRAIN, DONE.
- IDLE/DONE with start_i=1: capture P, clear done_o/fail_o, set address counter to 0, go to W_UP.
- Element 1, W_UP: write P at address 0..N-1, one address per cycle.
- Element 2, RW_UP_R/RW_UP_W: for address 0..N-1, read (expect P), then write ~P at the same address.
- Element 3, RW_DN_R/RW_DN_W: for address N-1..0, read (expect ~P), then write P.
- Element 4, R_DN: read address N-1..0 (expect P), one address per cycle.
- Each element transitions on the last address (N-1 when ascending, 0 when descending). The counter reloads to N-1 for descending elements and to 0 for ascending elements. There are no idle cycles between elements.
- Compare pipeline: every issued read registers {addr, expected, valid}. In the following cycle mem_Q is compared with expected. The compare runs independently of the FSM state, so the last read of an element is checked while the next element issues.
- First mismatch: latch fail_addr_o/fail_data_o and set fail_o. The FSM goes to DONE at the next posedge. A bus access already driven in the detection cycle completes. Later mismatches are ignored.
- After R_DN, DRAIN (CEN=1) checks the final read, then the FSM goes to DONE.
- DONE: busy_o=0, done_o=1, mem_CEN=1.
- Reset asserted mid-run: all outputs return to reset values asynchronously, and mem_CEN=1 immediately. The memory contents are left undefined.

## Timing
- Counting start-accept posedge as edge 0: bus cycles run from edge 0 to edge 6N, DRAIN lasts to edge 6N+1, and done_o rises after edge 6N+1. busy_o is high between those edges.
- Read latency is 1 cycle. Q is compared in the cycle after the read is issued.
- Abort latency: done_o rises 2 edges after the edge that sampled the failing read.
- Outputs are registered. The memory-side signals have no combinational path from mem_Q.

## Structure
- Package `sram_bist_pkg`: FSM state enum and element-direction enum.
- Sub-module `sram_bist_addr_gen`: up/down address counter with load, enable and a last-address flag.
- The FSM, data muxing and compare pipeline are in the top module.

## Test plan
All scenarios use ADDR_WIDTH=2, DATA_WIDTH=32, with the DUT connected to a `generic_memory_data` instance.
- Clean run, pattern 0xA5A55A5A: done_o rises after edge 25, fail_o=0, and all 4 words read back 0xA5A55A5A.
- Bus-sequence monitor: A is 0,1,2,3 | 0,0,1,1,2,2,3,3 | 3,3,2,2,1,1,0,0 | 3,2,1,0, with WEN matching write/read-write/read-write/read, and BEN always 0.
- Stuck-at-0 on bit 0 of word 2, pattern 0x00000001: fail_o=1, fail_addr_o=2, fail_data_o=0x00000000. The failure is found in element 2, and done_o rises 2 edges after the failing read.
- Stuck-at-1 on bit 31 of word 1, pattern 0x00000000: the failure is found in element 2 at address 1 with fail_data_o=0x80000000. No second mismatch is latched.
- start_i pulsed at edge 5 and held high after done: the mid-run start is ignored. The held start restarts the test, clearing done_o and fail_o.
- RSTN asserted at cycle 10: mem_CEN=1 and busy_o=0 immediately. A subsequent start runs a clean 25-edge test.
